fp_round_pack: RTL and testbench

Rounding and packing stage of the single-precision add/sub datapath, directly downstream of the mantissa normalizer. Accepts a normalized 24-bit significand with guard/round/sticky bits, a signed working exponent and a sign. Rounds, re-normalizes on rounding carry, detects overflow/underflow and packs a 32-bit IEEE-754 word. Two-stage pipeline with valid/ready handshake on both sides.

---
 rtl/fp_round_pack.sv | 168 ++++++++++++++++
 tb/tb_fp_round_pack.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_round_pack.sv
// -----------------------------------------------------------------------------
// fp_round_pack
// Rounding and packing stage of the single-precision add/sub datapath.
// Takes a normalized 24-bit significand plus guard/round/sticky bits, a signed
// working exponent and a sign. It rounds, re-normalizes on a rounding carry,
// detects overflow and underflow, and packs an IEEE-754 single-precision word.
// The block is a two-stage pipeline with a valid/ready handshake on each side.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  input handshake
//   sign_i             result sign
//   exp_i  [EXP_W]     biased working exponent, two's complement
//   mant_i [24]        normalized significand (bit 23 = hidden 1), 0 = exact zero
//   grs_i  [3]         guard, round, sticky bits below mant_i[0]
//   out_valid/out_ready output handshake
//   result_o [32]      packed {sign, exp[7:0], frac[22:0]}
//   ovf_o, unf_o, inx_o, zero_o   overflow, underflow (flushed), inexact, zero
//
// Configuration macro:
//   FP_ROUND_NEAREST_EN  defined   -> round to nearest, ties to even
//                        undefined -> truncation (no stage-1 incrementer)
// -----------------------------------------------------------------------------
module fp_round_pack #(
   parameter int EXP_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sign_i,
   input  logic [EXP_W-1:0] exp_i,
   input  logic [23:0]      mant_i,
   input  logic [2:0]       grs_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      result_o,
   output logic             ovf_o,
   output logic             unf_o,
   output logic             inx_o,
   output logic             zero_o
);

   localparam logic signed [EXP_W:0] EXP_MAX  = (EXP_W+1)'(255);
   localparam logic signed [EXP_W:0] EXP_ZERO = (EXP_W+1)'(0);

   // ---------------------------------------------------------------- control
   logic s1_valid;
   logic s2_valid;
   logic s1_load;
   logic s2_load;

   // Each stage advances when it is empty or its contents move on, so the
   // pipe keeps two beats in flight and runs at one beat per cycle.
   assign s2_load   = !s2_valid || out_ready;
   assign s1_load   = !s1_valid || s2_load;
   assign in_ready  = s1_load;
   assign out_valid = s2_valid;

   // ------------------------------------------------------------ stage 1 comb
   logic [24:0] sum25;

`ifdef FP_ROUND_NEAREST_EN
   logic inc;
   // Round up when above the halfway point, or exactly halfway with an odd LSB.
   assign inc   = grs_i[2] & (grs_i[1] | grs_i[0] | mant_i[0]);
   assign sum25 = {1'b0, mant_i} + {24'd0, inc};
`else
   assign sum25 = {1'b0, mant_i};
`endif

   // ------------------------------------------------------------ stage 1 regs
   logic             s1_sign;
   logic [EXP_W-1:0] s1_exp;
   logic [24:0]      s1_sum;
   logic             s1_zero;
   logic             s1_inx;

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_exp   <= '0;
         s1_sum   <= '0;
         s1_zero  <= 1'b0;
         s1_inx   <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_valid <= in_valid;
         end
         if (s1_load && in_valid) begin
            s1_sign <= sign_i;
            s1_exp  <= exp_i;
            s1_sum  <= sum25;
            s1_zero <= (mant_i == 24'd0);
            s1_inx  <= |grs_i;
         end
      end
   end

   // ------------------------------------------------------------ stage 2 comb
   logic                    carry;
   logic [22:0]             frac;
   logic signed [EXP_W:0]   exp_fin;
   logic [31:0]             nx_result;
   logic                    nx_ovf;
   logic                    nx_unf;
   logic                    nx_inx;
   logic                    nx_zero;

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      carry     = s1_sum[24];
      frac      = carry ? s1_sum[23:1] : s1_sum[22:0];
      // One extra bit keeps exp+1 from wrapping; the compares below are signed.
      exp_fin   = {s1_exp[EXP_W-1], s1_exp} + {{EXP_W{1'b0}}, carry};
      nx_result = {s1_sign, 31'd0};
      nx_ovf    = 1'b0;
      nx_unf    = 1'b0;
      nx_inx    = 1'b0;
      nx_zero   = 1'b0;

      if (s1_zero) begin
         nx_zero = 1'b1;
      end else if (exp_fin >= EXP_MAX) begin
         nx_result = {s1_sign, 8'hFF, 23'd0};
         nx_ovf    = 1'b1;
         nx_inx    = 1'b1;
      end else if (exp_fin <= EXP_ZERO) begin
         // No subnormal output: tiny results flush to signed zero.
         nx_unf  = 1'b1;
         nx_inx  = 1'b1;
         nx_zero = 1'b1;
      end else begin
         nx_result = {s1_sign, exp_fin[7:0], frac};
         nx_inx    = s1_inx;
      end
   end

   // ------------------------------------------------------------ stage 2 regs
   // NOTE: the output data registers are reset as well as the valid bits, so
   // result_o and the flags read zero after reset, not a stale beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         result_o <= '0;
         ovf_o    <= 1'b0;
         unf_o    <= 1'b0;
         inx_o    <= 1'b0;
         zero_o   <= 1'b0;
      end else begin
         if (s2_load) begin
            s2_valid <= s1_valid;
         end
         if (s2_load && s1_valid) begin
            result_o <= nx_result;
            ovf_o    <= nx_ovf;
            unf_o    <= nx_unf;
            inx_o    <= nx_inx;
            zero_o   <= nx_zero;
         end
      end
   end

endmodule

// File: tb/tb_fp_round_pack.sv
// -----------------------------------------------------------------------------
// tb_fp_round_pack
// Self-checking bench for fp_round_pack. The stimulus side pushes the expected
// response of each accepted beat into a scoreboard queue; an independent
// monitor pops and compares whenever the DUT emits a result, and also checks
// that a stalled output holds steady. Expected values come from hand-derived
// constants (directed vectors) or from an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fp_round_pack;

   localparam int EXP_W = 10;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             sign_i = 1'b0;
   logic [EXP_W-1:0] exp_i = '0;
   logic [23:0]      mant_i = '0;
   logic [2:0]       grs_i = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      result_o;
   logic             ovf_o, unf_o, inx_o, zero_o;
   logic [3:0]       flags;

   assign flags = {ovf_o, unf_o, inx_o, zero_o};

   fp_round_pack #(.EXP_W(EXP_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sign_i    (sign_i),
      .exp_i     (exp_i),
      .mant_i    (mant_i),
      .grs_i     (grs_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result_o  (result_o),
      .ovf_o     (ovf_o),
      .unf_o     (unf_o),
      .inx_o     (inx_o),
      .zero_o    (zero_o)
   );

   always #5 clk = ~clk;

   // flags field ordering: {ovf, unf, inx, zero}
   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  flags;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_idle(input string name);
      check(name, {2'b00, out_valid, in_ready, result_o, flags},
                  {2'b00, 1'b0, 1'b1, 32'd0, 4'd0});
   endtask

   // Reference model: treat {mant, grs} as an integer, round with plain
   // arithmetic, then classify the final exponent.
   function automatic exp_t model(input logic s, input logic [EXP_W-1:0] e,
                                  input logic [23:0] m, input logic [2:0] g);
      exp_t   r;
      int     ev;
      longint q;
      ev = int'($signed(e));
      q  = longint'(m);
      r.res   = {s, 31'd0};
      r.flags = 4'b0000;
      if (m == 24'd0) begin
         r.flags = 4'b0001;
         return r;
      end
`ifdef FP_ROUND_NEAREST_EN
      if (g > 3'd4 || (g == 3'd4 && (q % 2) == 1)) q = q + 1;
`endif
      if (q >= 64'sd16777216) begin
         q  = q / 2;
         ev = ev + 1;
      end
      if (ev >= 255) begin
         r.res   = {s, 8'hFF, 23'd0};
         r.flags = 4'b1010;
      end else if (ev <= 0) begin
         r.res   = {s, 31'd0};
         r.flags = 4'b0111;
      end else begin
         r.res   = {s, 8'(ev), 23'(q)};
         r.flags = {2'b00, (g != 3'd0), 1'b0};
      end
      return r;
   endfunction

   task automatic rand_beat(output logic s, output logic [EXP_W-1:0] e,
                            output logic [23:0] m, output logic [2:0] g);
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
         0:       e = EXP_W'($urandom);
         1:       e = EXP_W'($urandom_range(0, 3));
         2:       e = EXP_W'($urandom_range(252, 256));
         3:       e = EXP_W'(1024 - $urandom_range(1, 20));
         default: e = EXP_W'($urandom_range(1, 254));
      endcase
      case ($urandom_range(0, 7))
         0:       m = 24'd0;
         1:       m = 24'hFFFFFF;
         default: m = {1'b1, 23'($urandom)};
      endcase
      g = 3'($urandom);
   endtask

   // Present one beat and push its expected response when it is accepted.
   task automatic drive_beat(input logic s, input logic [EXP_W-1:0] e,
                             input logic [23:0] m, input logic [2:0] g, input exp_t req);
      bit done = 1'b0;
      sign_i   = s;
      exp_i    = e;
      mant_i   = m;
      grs_i    = g;
      in_valid = 1'b1;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(req);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
      end
   endtask

   task automatic drive_rand;
      logic s;
      logic [EXP_W-1:0] e;
      logic [23:0] m;
      logic [2:0] g;
      rand_beat(s, e, m, g);
      drive_beat(s, e, m, g, model(s, e, m, g));
   endtask

   task automatic drain(input string name);
      out_ready = 1'b1;
      for (int t = 0; t < 300 && (sb.size() != 0 || out_valid); t++) begin
         @(posedge clk);
         #1;
      end
      check(name, 40'(sb.size()), 40'd0);
   endtask

   // ------------------------------------------------------------- monitor
   logic        stalled = 1'b0;
   logic [35:0] held = '0;

   initial begin
      exp_t req;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               check("stall_valid", 40'(out_valid), 40'd1);
               check("stall_hold", {4'd0, result_o, flags}, {4'd0, held});
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_output: got %h/%b, expected no output", result_o, flags);
               end else begin
                  req = sb.pop_front();
                  check("result", 40'(result_o), 40'(req.res));
                  check("flags", 40'(flags), 40'(req.flags));
               end
            end
            stalled = out_valid && !out_ready;
            held    = {result_o, flags};
         end
      end
   end

   // ------------------------------------------------------------- stimulus
`ifdef FP_ROUND_NEAREST_EN
   localparam exp_t X_CARRY   = {32'h40000000, 4'b0010};
   localparam exp_t X_TIE_ODD = {32'h3F800002, 4'b0010};
   localparam exp_t X_OVF_RND = {32'hFF800000, 4'b1010};
   localparam exp_t X_RND_UP  = {32'h41000004, 4'b0010};
`else
   localparam exp_t X_CARRY   = {32'h3FFFFFFF, 4'b0010};
   localparam exp_t X_TIE_ODD = {32'h3F800001, 4'b0010};
   localparam exp_t X_OVF_RND = {32'hFF7FFFFF, 4'b0010};
   localparam exp_t X_RND_UP  = {32'h41000003, 4'b0010};
`endif

   logic             r_s;
   logic [EXP_W-1:0] r_e;
   logic [23:0]      r_m;
   logic [2:0]       r_g;
   logic [35:0]      snap;

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset_idle");
      rst_n = 1'b1;
      #1;
      check_idle("after_release");
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      // Directed vectors
      drive_beat(1'b0, 10'd127,   24'hFFFFFF, 3'b100, X_CARRY);
      drive_beat(1'b0, 10'd127,   24'h800000, 3'b100, {32'h3F800000, 4'b0010});
      drive_beat(1'b0, 10'd127,   24'h800001, 3'b100, X_TIE_ODD);
      drive_beat(1'b0, 10'd130,   24'h800003, 3'b101, X_RND_UP);
      drive_beat(1'b1, 10'd254,   24'hFFFFFF, 3'b110, X_OVF_RND);
      drive_beat(1'b0, 10'd255,   24'h800000, 3'b000, {32'h7F800000, 4'b1010});
      drive_beat(1'b0, 10'h1FF,   24'h800000, 3'b000, {32'h7F800000, 4'b1010});
      drive_beat(1'b0, 10'd0,     24'h800000, 3'b000, {32'h00000000, 4'b0111});
      drive_beat(1'b1, 10'h3FB,   24'hC00000, 3'b001, {32'h80000000, 4'b0111});
      drive_beat(1'b0, 10'd1,     24'h800000, 3'b000, {32'h00800000, 4'b0000});
      drive_beat(1'b1, 10'd50,    24'h000000, 3'b000, {32'h80000000, 4'b0001});
      drive_beat(1'b0, 10'd50,    24'h000000, 3'b111, {32'h00000000, 4'b0001});
      drain("drain_directed");

      // Backpressure: two beats fill the pipe, input side must then stall
      out_ready = 1'b0;
      drive_rand();
      drive_rand();
      check("bp_in_ready", 40'(in_ready), 40'd0);
      check("bp_out_valid", 40'(out_valid), 40'd1);
      snap = {result_o, flags};
      repeat (3) @(posedge clk);
      #1;
      check("bp_in_ready_held", 40'(in_ready), 40'd0);
      check("bp_result_held", {4'd0, result_o, flags}, {4'd0, snap});
      out_ready = 1'b1;
      drive_rand();
      drive_rand();
      drain("drain_backpressure");

      // Randomized traffic with random gaps and random backpressure
      in_valid = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         bit acc;
         out_ready = ($urandom_range(0, 3) != 0);
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            rand_beat(r_s, r_e, r_m, r_g);
            sign_i   = r_s;
            exp_i    = r_e;
            mant_i   = r_m;
            grs_i    = r_g;
            in_valid = 1'b1;
         end
         @(negedge clk);
         acc = in_valid && in_ready;
         if (acc) sb.push_back(model(sign_i, exp_i, mant_i, grs_i));
         @(posedge clk);
         #1;
         if (acc) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      drain("drain_random");

      // Reset with two beats in flight
      out_ready = 1'b0;
      drive_rand();
      drive_rand();
      #3;
      rst_n = 1'b0;
      #1;
      check_idle("reset_async");
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_idle("reset_mid_release");
      out_ready = 1'b1;
      for (int t = 0; t < 6; t++) begin
         @(posedge clk);
         #1;
         check("no_stale", 40'(out_valid), 40'd0);
      end
      drive_beat(1'b0, 10'd127, 24'h800000, 3'b000, {32'h3F800000, 4'b0000});
      drain("drain_after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "time limit reached");
   end

endmodule
